// File: rtl/ex_wb_stage.sv
// ex_wb_stage
//   EX/WB pipeline stage. Captures one executed instruction per cycle,
//   selects the write-back value, owns the architectural N/Z flags, resolves
//   BRZ/BRN/J/JM, emits a one-cycle redirect, and discards a fixed number of
//   wrong-path instructions after a taken branch.
//
// Handshake: an input bundle is consumed on a rising edge exactly when
//   in_valid=1 and stall=0. There is no back-pressure output; the upstream
//   holds the bundle while stall=1.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   stall, in_valid      capture control
//   alu_out, alu_n/z     ALU result and flags
//   flag_wr              instruction updates N/Z
//   mem_rdata, wb_sel    load data and write-back source select
//   reg_wr, rd           register write request and destination
//   br_type, br_target   branch kind (00 none, 01 jump, 10 BRZ, 11 BRN), target
//   wb_valid/en/rd/data  registered retire / write-back bundle
//   flag_n, flag_z       architectural flags
//   redirect, redirect_pc  registered one-cycle fetch redirect
module ex_wb_stage #(
  parameter int SQUASH_DEPTH = 2,
  parameter int RD_W         = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            in_valid,
  input  logic [31:0]     alu_out,
  input  logic            alu_n,
  input  logic            alu_z,
  input  logic            flag_wr,
  input  logic [31:0]     mem_rdata,
  input  logic            wb_sel,
  input  logic            reg_wr,
  input  logic [RD_W-1:0] rd,
  input  logic [1:0]      br_type,
  input  logic [31:0]     br_target,
  output logic            wb_valid,
  output logic            wb_en,
  output logic [RD_W-1:0] wb_rd,
  output logic [31:0]     wb_data,
  output logic            flag_n,
  output logic            flag_z,
  output logic            redirect,
  output logic [31:0]     redirect_pc
);

  localparam logic [2:0] SQ_LOAD = 3'(SQUASH_DEPTH);

  logic            wb_valid_q,    wb_valid_d;
  logic            wb_en_q,       wb_en_d;
  logic [RD_W-1:0] wb_rd_q,       wb_rd_d;
  logic [31:0]     wb_data_q,     wb_data_d;
  logic            flag_n_q,      flag_n_d;
  logic            flag_z_q,      flag_z_d;
  logic            redirect_q,    redirect_d;
  logic [31:0]     redirect_pc_q, redirect_pc_d;
  logic [2:0]      sq_cnt_q,      sq_cnt_d;

  logic capture;
  logic live;
  logic squash_cap;
  logic taken;

  assign capture    = in_valid & ~stall;
  assign live       = capture & (sq_cnt_q == 3'd0);
  assign squash_cap = capture & (sq_cnt_q != 3'd0);

  // Branch condition reads the flag register as it stands before this edge;
  // a flag write by the previous instruction has therefore already landed.
  assign taken = live & ((br_type == 2'b01) |
                         ((br_type == 2'b10) & flag_z_q) |
                         ((br_type == 2'b11) & flag_n_q));

  always_comb begin
    wb_valid_d    = 1'b0;
    wb_en_d       = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    flag_n_d      = flag_n_q;
    flag_z_d      = flag_z_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    sq_cnt_d      = sq_cnt_q;

    // Only discarded instructions consume squash count; stalls and bubbles
    // leave it alone.
    if (squash_cap) begin
      sq_cnt_d = sq_cnt_q - 3'd1;
    end

    if (live) begin
      wb_valid_d = 1'b1;
      wb_en_d    = reg_wr;
      wb_rd_d    = rd;
      wb_data_d  = wb_sel ? mem_rdata : alu_out;
      if (flag_wr) begin
        flag_n_d = alu_n;
        flag_z_d = alu_z;
      end
      if (taken) begin
        redirect_d    = 1'b1;
        redirect_pc_d = br_target;
        sq_cnt_d      = SQ_LOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q    <= 1'b0;
      wb_en_q       <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      flag_n_q      <= 1'b0;
      flag_z_q      <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      sq_cnt_q      <= '0;
    end else begin
      wb_valid_q    <= wb_valid_d;
      wb_en_q       <= wb_en_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      flag_n_q      <= flag_n_d;
      flag_z_q      <= flag_z_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      sq_cnt_q      <= sq_cnt_d;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_en       = wb_en_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign flag_n      = flag_n_q;
  assign flag_z      = flag_z_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Testbench for ex_wb_stage: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of the stage.
module tb_ex_wb_stage;

  localparam int SQ   = 2;
  localparam int RD_W = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic            stall, in_valid, alu_n, alu_z, flag_wr, wb_sel, reg_wr;
  logic [31:0]     alu_out, mem_rdata, br_target;
  logic [RD_W-1:0] rd;
  logic [1:0]      br_type;
  logic            wb_valid, wb_en, flag_n, flag_z, redirect;
  logic [RD_W-1:0] wb_rd;
  logic [31:0]     wb_data, redirect_pc;

  ex_wb_stage #(.SQUASH_DEPTH(SQ), .RD_W(RD_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .in_valid(in_valid),
    .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z), .flag_wr(flag_wr),
    .mem_rdata(mem_rdata), .wb_sel(wb_sel), .reg_wr(reg_wr), .rd(rd),
    .br_type(br_type), .br_target(br_target),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_n(flag_n), .flag_z(flag_z), .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural view: what the stage should show after each edge.
  logic        m_valid, m_en, m_fn, m_fz, m_redir;
  logic [31:0] m_rd, m_data, m_pc;
  int          m_discard;   // wrong-path instructions still to be dropped

  task automatic model_reset();
    m_valid = 0; m_en = 0; m_fn = 0; m_fz = 0; m_redir = 0;
    m_rd = 0; m_data = 0; m_pc = 0; m_discard = 0;
  endtask

  task automatic model_edge();
    bit take;
    m_valid = 0; m_en = 0; m_redir = 0;
    if (in_valid && !stall) begin
      if (m_discard > 0) begin
        m_discard = m_discard - 1;
      end else begin
        case (br_type)
          2'b01:   take = 1;
          2'b10:   take = m_fz;
          2'b11:   take = m_fn;
          default: take = 0;
        endcase
        m_valid = 1;
        m_en    = reg_wr;
        m_rd    = 32'(rd);
        m_data  = wb_sel ? mem_rdata : alu_out;
        if (flag_wr) begin m_fn = alu_n; m_fz = alu_z; end
        if (take) begin
          m_redir   = 1;
          m_pc      = br_target;
          m_discard = SQ;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".wb_valid"},    32'(wb_valid),    32'(m_valid));
    check_eq({tag, ".wb_en"},       32'(wb_en),       32'(m_en));
    check_eq({tag, ".wb_rd"},       32'(wb_rd),       m_rd);
    check_eq({tag, ".wb_data"},     wb_data,          m_data);
    check_eq({tag, ".flag_n"},      32'(flag_n),      32'(m_fn));
    check_eq({tag, ".flag_z"},      32'(flag_z),      32'(m_fz));
    check_eq({tag, ".redirect"},    32'(redirect),    32'(m_redir));
    check_eq({tag, ".redirect_pc"}, redirect_pc,      m_pc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic op(input string tag, input logic v, input logic st,
                    input logic [31:0] a, input logic n, input logic z,
                    input logic fw, input logic [31:0] md, input logic sel,
                    input logic rw, input logic [RD_W-1:0] r,
                    input logic [1:0] bt, input logic [31:0] tgt);
    in_valid = v; stall = st; alu_out = a; alu_n = n; alu_z = z;
    flag_wr = fw; mem_rdata = md; wb_sel = sel; reg_wr = rw; rd = r;
    br_type = bt; br_target = tgt;
    step(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0;
    in_valid = 0; stall = 0; alu_out = 0; alu_n = 0; alu_z = 0; flag_wr = 0;
    mem_rdata = 0; wb_sel = 0; reg_wr = 0; rd = 0; br_type = 0; br_target = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk) rst_n = 1;

    // Load the squash counter, then reset mid-cycle.
    op("pre_flags", 1, 0, 32'h7, 1, 1, 1, 0, 0, 1, 6'd9, 2'b00, 0);
    op("j_pre_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 6'd0, 2'b01, 32'h200);
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk) rst_n = 1;
    op("add_after_rst", 1, 0, 32'd5, 0, 0, 1, 0, 0, 1, 6'd3, 2'b00, 0);
    check_eq("add_after_rst.en_lit",   32'(wb_en), 32'd1);
    check_eq("add_after_rst.data_lit", wb_data,    32'd5);

    // Load select, flags untouched.
    op("ld_sel", 1, 0, 32'h10, 1, 1, 0, 32'hDEADBEEF, 1, 1, 6'd7, 2'b00, 0);
    check_eq("ld_sel.data_lit", wb_data, 32'hDEADBEEF);

    // SUB sets Z, BRZ taken immediately after.
    op("sub_z1", 1, 0, 32'h0, 0, 1, 1, 0, 0, 1, 6'd4, 2'b00, 0);
    op("brz_t",  1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 6'd0, 2'b10, 32'h40);
    check_eq("brz_t.redir_lit", 32'(redirect), 32'd1);
    check_eq("brz_t.pc_lit",    redirect_pc,   32'h40);
    op("wp0", 1, 0, 32'h1, 0, 0, 0, 0, 0, 1, 6'd1, 2'b00, 0);
    op("wp1", 1, 0, 32'h2, 0, 0, 0, 0, 0, 1, 6'd2, 2'b00, 0);
    // SUB clears Z, BRZ not taken.
    op("sub_z0", 1, 0, 32'h3, 0, 0, 1, 0, 0, 1, 6'd4, 2'b00, 0);
    op("brz_nt", 1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 6'd0, 2'b10, 32'h44);

    // NEG sets N, INC clears it, BRN not taken.
    op("neg",    1, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 1, 6'd5, 2'b00, 0);
    op("inc",    1, 0, 32'h1,        0, 0, 1, 0, 0, 1, 6'd5, 2'b00, 0);
    op("brn_nt", 1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 6'd0, 2'b11, 32'h80);

    // Jump, stall between wrong-path ADDs; third ADD writes.
    op("j",       1, 0, 0,      0, 0, 0, 0, 0, 0, 6'd0,  2'b01, 32'h100);
    op("sq_add0", 1, 0, 32'hA1, 0, 0, 0, 0, 0, 1, 6'd10, 2'b00, 0);
    op("sq_stl",  1, 1, 32'hA2, 0, 0, 0, 0, 0, 1, 6'd11, 2'b00, 0);
    op("sq_add1", 1, 0, 32'hA2, 0, 0, 0, 0, 0, 1, 6'd11, 2'b00, 0);
    op("sq_add2", 1, 0, 32'hA3, 0, 0, 0, 0, 0, 1, 6'd12, 2'b00, 0);
    check_eq("sq_add2.en_lit", 32'(wb_en), 32'd1);

    // Stall hold with a flag-writing instruction waiting.
    for (int i = 0; i < 3; i++)
      op("stall_hold", 1, 1, 32'h55, 1, 1, 1, 0, 0, 1, 6'd20, 2'b00, 0);
    op("stall_rel", 1, 0, 32'h55, 1, 1, 1, 0, 0, 1, 6'd20, 2'b00, 0);

    // Taken branch followed by a stall: pulse must still be one cycle.
    op("j_stl",  1, 0, 0, 0, 0, 0, 0, 0, 0, 6'd0, 2'b01, 32'h300);
    op("j_stl1", 1, 1, 0, 0, 0, 0, 0, 0, 0, 6'd0, 2'b00, 0);
    op("j_stl2", 1, 1, 0, 0, 0, 0, 0, 0, 0, 6'd0, 2'b00, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] bt;
      bt = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      op("rand", 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) == 0),
         $urandom, 1'($urandom), 1'($urandom),
         (bt == 2'b00) ? 1'($urandom) : 1'b0,
         $urandom, 1'($urandom), 1'($urandom), 6'($urandom),
         bt, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_wb_stage.md
# ex_wb_stage

EX/WB pipeline stage of the SCU-ISA pipelined CPU, sitting directly downstream of the ALU and the data-memory read port. Each cycle it captures one executed instruction and selects the write-back value (ALU result or memory data). It owns the architectural N/Z flag register, which is updated only by flag-writing ALU instructions. It resolves BRZ/BRN/J/JM, emits a one-cycle redirect, and squashes a fixed number of wrong-path instructions after a taken branch.

## Interface

Parameters:
- SQUASH_DEPTH, 2: valid instructions discarded after a taken branch (range 0-7).
- RD_W, 6: register-index width (64 registers).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  upstream not advancing; the input is not captured this cycle.
- in_valid  in  1  input bundle holds a real instruction.
- alu_out  in  32  ALU result.
- alu_n, alu_z  in  1 each  ALU negative and zero flags.
- flag_wr  in  1  instruction updates N/Z (ADD, INC, NEG, SUB).
- mem_rdata  in  32  data-memory read data (LD).
- wb_sel  in  1  0 selects alu_out; 1 selects mem_rdata.
- reg_wr  in  1  instruction writes rd.
- rd  in  RD_W  destination register.
- br_type  in  2  00 none; 01 unconditional (J/JM); 10 BRZ; 11 BRN.
- br_target  in  32  branch/jump target address.
- wb_valid  out  1  registered; a retired (non-squashed) instruction is present.
- wb_en  out  1  registered; register-file write enable.
- wb_rd  out  RD_W  registered destination.
- wb_data  out  32  registered write-back data.
- flag_n, flag_z  out  1 each  architectural flags (register outputs).
- redirect  out  1  registered one-cycle pulse; fetch must load redirect_pc.
- redirect_pc  out  32  registered target, meaningful only while redirect=1.

## Operation

- Capture condition: capture = in_valid & !stall.
- Squash counter sq_cnt (3 bits):
  - A captured instruction is squashed when sq_cnt != 0. sq_cnt decrements by 1 per squashed capture.
  - Squashed instructions do not write, do not update flags, and do not branch.
- Live capture (capture & sq_cnt==0):
  - wb_valid<=1.
  - wb_en<=reg_wr.
  - wb_rd<=rd.
  - wb_data<=wb_sel ? mem_rdata : alu_out.
  - If flag_wr, then flag_n<=alu_n and flag_z<=alu_z; otherwise the flags hold.
- Branch decision on a live capture:
  - taken = (br_type==01) | (br_type==10 & flag_z) | (br_type==11 & flag_n).
  - The decision uses the flag register value before this edge. Branches never set flag_wr; a branch with flag_wr=1 is illegal input.
- If taken:
  - redirect<=1 and redirect_pc<=br_target.
  - sq_cnt<=SQUASH_DEPTH.
  - The branch itself retires with the wb_en it was given (JM/J normally 0).
- No capture (stall, or in_valid=0), or squashed capture: wb_valid<=0, wb_en<=0, redirect<=0. wb_rd, wb_data and redirect_pc hold their previous values. Flags hold.
- A stall does not decrement sq_cnt. Invalid cycles do not decrement sq_cnt either; only discarded instructions are counted.
- A taken branch cannot arrive while sq_cnt != 0, because it would be squashed.

## Timing

- Reset (rst_n=0, asynchronous, any time, including mid-squash): all of the following go to 0 immediately and stay 0 until the first edge after release:
  - wb_valid, wb_en, wb_rd, wb_data
  - flag_n, flag_z
  - redirect, redirect_pc
  - sq_cnt
- Latency: input at edge k appears on wb_* and redirect during cycle k+1. There is no combinational path from any input to any output.
- redirect is high for exactly one cycle per taken branch, including when stall rises in the following cycle.
- Back-to-back: a flag-writing op at edge k followed by BRZ at edge k+1 sees the updated flag_z. This is the required forwarding behaviour.
- SQUASH_DEPTH=0: the counter never loads, and no instructions are discarded.

## Test plan

- Reset: assert rst_n=0 mid-cycle with sq_cnt=2 -> all outputs are 0 asynchronously. After release, the next valid ADD (alu_out=5, reg_wr=1, rd=3) gives wb_en=1, wb_rd=3, wb_data=5 one cycle later.
- LD select: wb_sel=1, mem_rdata=0xDEADBEEF, alu_out=0x10 -> wb_data=0xDEADBEEF. Flags are unchanged with flag_wr=0.
- Flags and BRZ: SUB with alu_out=0, alu_z=1, flag_wr=1, then BRZ with br_target=0x40 on the next cycle -> flag_z=1; redirect=1 for one cycle with redirect_pc=0x40. With alu_z=0 instead, redirect stays 0.
- BRN not taken on a stale flag: NEG sets flag_n=1, INC clears it (alu_n=0), then BRN -> no redirect.
- Squash (SQUASH_DEPTH=2): J to 0x100, then three ADDs with reg_wr=1 -> redirect pulse occurs; the first two ADDs give wb_valid=0 and wb_en=0, and the third writes. A stall inserted between them does not consume squash count.
- Stall hold: stall=1 for 3 cycles with in_valid=1 -> wb_valid=0, no flag change, no redirect. The instruction is captured on the first edge with stall=0.
